// File: rtl/ksa_scheduler.sv
// RC4 key-scheduling stage: permutes the shared 256-entry S RAM under a secret key, 5 cycles per index.
// Optional macro KSA_INIT_EN inserts an INIT state that first fills S with the identity permutation.
module ksa_scheduler #(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_LENGTH = 8,
    parameter int KEY_LENGTH = 24,
    parameter int KEY_BYTES  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KEY_LENGTH-1:0] key,
    input  logic [RAM_WIDTH-1:0]  sOut,
    output logic [RAM_WIDTH-1:0]  sIn,
    output logic [RAM_LENGTH-1:0] sAddr,
    output logic                  sWren,
    output logic [7:0]            iTap,
    output logic [7:0]            jTap,
    output logic [7:0]            stateTap,
    output logic                  finished
);

`ifdef KSA_INIT_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ_I  = 3'd1,
        LATCH_I = 3'd2,
        LATCH_J = 3'd3,
        WRITE_I = 3'd4,
        WRITE_J = 3'd5,
        DONE    = 3'd6,
        INIT    = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ_I  = 3'd1,
        LATCH_I = 3'd2,
        LATCH_J = 3'd3,
        WRITE_I = 3'd4,
        WRITE_J = 3'd5,
        DONE    = 3'd6
    } state_t;
`endif

    localparam logic [RAM_LENGTH-1:0] I_LAST    = {RAM_LENGTH{1'b1}};
    localparam logic [7:0]            KIDX_LAST = 8'(KEY_BYTES - 1);

    state_t                  state_q, state_d;
    logic [RAM_LENGTH-1:0]   i_q, i_d;
    logic [RAM_LENGTH-1:0]   j_q, j_d;
    logic [RAM_WIDTH-1:0]    si_q, si_d;
    logic [RAM_WIDTH-1:0]    sj_q, sj_d;
    logic [KEY_LENGTH-1:0]   key_q, key_d;
    logic [7:0]              kidx_q, kidx_d;
    logic [RAM_LENGTH-1:0]   jn;

    // Key byte 0 is the most significant byte of the key.
    function automatic logic [7:0] key_byte(input logic [KEY_LENGTH-1:0] k, input logic [7:0] idx);
        logic [KEY_LENGTH-1:0] sh;
        sh = k >> (8 * (KEY_BYTES - 1 - int'(idx)));
        return sh[7:0];
    endfunction

    // jn feeds sAddr directly in LATCH_I so the S[j] read lands one cycle later.
    assign jn = j_q + RAM_LENGTH'(sOut) + RAM_LENGTH'(key_byte(key_q, kidx_q));

    assign iTap     = 8'(i_q);
    assign jTap     = 8'(j_q);
    assign stateTap = {5'd0, state_q};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            key_q   <= '0;
            kidx_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
            kidx_q  <= kidx_d;
        end
    end

    // Next-state logic and RAM-side output decode.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        si_d     = si_q;
        sj_d     = sj_q;
        key_d    = key_q;
        kidx_d   = kidx_q;
        sAddr    = '0;
        sIn      = '0;
        sWren    = 1'b0;
        finished = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d  = key;
                    i_d    = '0;
                    j_d    = '0;
                    kidx_d = 8'd0;
`ifdef KSA_INIT_EN
                    state_d = INIT;
`else
                    state_d = READ_I;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef KSA_INIT_EN
            INIT: begin
                sAddr = i_q;
                sIn   = RAM_WIDTH'(i_q);
                sWren = 1'b1;
                if (i_q == I_LAST) begin
                    i_d     = '0;
                    state_d = READ_I;
                end else begin
                    i_d = i_q + RAM_LENGTH'(1);
                end
            end
`endif
            READ_I: begin
                sAddr   = i_q;
                state_d = LATCH_I;
            end
            LATCH_I: begin
                si_d    = sOut;
                j_d     = jn;
                sAddr   = jn;
                state_d = LATCH_J;
            end
            LATCH_J: begin
                sj_d    = sOut;
                sAddr   = j_q;
                state_d = WRITE_I;
            end
            WRITE_I: begin
                sAddr   = i_q;
                sIn     = sj_q;
                sWren   = 1'b1;
                state_d = WRITE_J;
            end
            WRITE_J: begin
                sAddr = j_q;
                sIn   = si_q;
                sWren = 1'b1;
                // Terminal test on the index value itself, i never overflows.
                if (i_q == I_LAST) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + RAM_LENGTH'(1);
                    kidx_d  = (kidx_q == KIDX_LAST) ? 8'd0 : kidx_q + 8'd1;
                    state_d = READ_I;
                end
            end
            DONE: begin
                finished = 1'b1;
                if (start) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ksa_scheduler.sv
// Self-checking bench for ksa_scheduler: stubbed-read j table, full schedules against a software KSA,
// reset abort, and DONE hold / rerun behaviour.
module tb_ksa_scheduler;

`ifdef KSA_INIT_EN
    localparam int INIT_CYC = 256;
`else
    localparam int INIT_CYC = 0;
`endif
    localparam int DONE_EDGE = INIT_CYC + 1280;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] key;
    logic [7:0]  sOut;
    logic [7:0]  sIn;
    logic [7:0]  sAddr;
    logic        sWren;
    logic [7:0]  iTap;
    logic [7:0]  jTap;
    logic [7:0]  stateTap;
    logic        finished;

    logic [7:0]  mem [256];
    logic [7:0]  model_s [256];
    logic [7:0]  rd_q;
    logic        use_stub;
    logic        load_id;
    logic        load_rnd;
    int          wr_count;
    int          tests;
    int          failed;

    typedef struct packed {
        logic [23:0]     key;
        logic [2:0][7:0] exp_j;
    } stub_vec_t;

    stub_vec_t tbl [3];

    ksa_scheduler #(
        .RAM_WIDTH (8),
        .RAM_LENGTH(8),
        .KEY_LENGTH(24),
        .KEY_BYTES (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .key     (key),
        .sOut    (sOut),
        .sIn     (sIn),
        .sAddr   (sAddr),
        .sWren   (sWren),
        .iTap    (iTap),
        .jTap    (jTap),
        .stateTap(stateTap),
        .finished(finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sOut = use_stub ? 8'h18 : rd_q;

    // Behavioural S RAM: registered read, write on the edge that samples sWren, plus bench preload.
    always @(posedge clk) begin
        if (load_id) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        end else if (load_rnd) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'($urandom);
        end else if (sWren === 1'b1) begin
            mem[sAddr] <= sIn;
        end
        rd_q <= mem[sAddr];
        if (sWren === 1'b1) wr_count <= wr_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Software RC4 key schedule starting from the identity permutation.
    task automatic ksa_model(input logic [23:0] k);
        int j;
        logic [7:0] t;
        logic [7:0] kb;
        for (int n = 0; n < 256; n++) model_s[n] = 8'(n);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            j = (j + int'(model_s[i]) + int'(kb)) % 256;
            t = model_s[i];
            model_s[i] = model_s[j];
            model_s[j] = t;
        end
    endtask

    task automatic check_ram(input string tag);
        int bad = 0;
        int first = 0;
        for (int n = 0; n < 256; n++) begin
            if (mem[n] !== model_s[n]) begin
                if (bad == 0) first = n;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL %s_sram: %0d entries differ, first at %0d got %0h expected %0h",
                     tag, bad, first, mem[first], model_s[first]);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic prep_ram();
        @(negedge clk);
        start = 1'b0;
`ifdef KSA_INIT_EN
        load_rnd = 1'b1;
`else
        load_id = 1'b1;
`endif
        @(posedge clk);
        #1;
        load_rnd = 1'b0;
        load_id  = 1'b0;
    endtask

    // Edge 0 is the first edge sampling start=1; returns the edge where finished is first seen.
    task automatic run_schedule(input logic [23:0] k, output int done_edge);
        done_edge = -1;
        @(negedge clk);
        key   = k;
        start = 1'b1;
        for (int e = 0; e < 4000; e++) begin
            @(posedge clk);
            #1;
            if (finished === 1'b1) begin
                done_edge = e;
                break;
            end
        end
    endtask

    task automatic full_run(input logic [23:0] k, input string tag);
        int done_edge;
        prep_ram();
        ksa_model(k);
        run_schedule(k, done_edge);
        check({tag, "_done_edge"}, done_edge, DONE_EDGE);
        check_ram(tag);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        int tgt;
        int w0;
        int bad;
        logic [23:0] rk;

        tests    = 0;
        failed   = 0;
        wr_count = 0;
        reset    = 1'b1;
        start    = 1'b0;
        key      = 24'h0;
        use_stub = 1'b0;
        load_id  = 1'b0;
        load_rnd = 1'b0;

        tbl[0] = '{key: 24'h000003, exp_j: {8'h4B, 8'h30, 8'h18}};
        tbl[1] = '{key: 24'h010203, exp_j: {8'h4E, 8'h33, 8'h19}};
        tbl[2] = '{key: 24'hFFFFFF, exp_j: {8'h45, 8'h2E, 8'h17}};

        repeat (3) @(posedge clk);
        #1;
        check("rst_sWren", {31'd0, sWren}, 32'd0);
        check("rst_sAddr", {24'd0, sAddr}, 32'd0);
        check("rst_sIn", {24'd0, sIn}, 32'd0);
        check("rst_finished", {31'd0, finished}, 32'd0);
        check("rst_iTap", {24'd0, iTap}, 32'd0);
        check("rst_jTap", {24'd0, jTap}, 32'd0);
        $display("[TB] state tap after reset = %0d", stateTap);
        @(negedge clk);
        reset = 1'b0;

        // Stubbed read data: j after the first three iterations.
        for (int v = 0; v < 3; v++) begin
            pulse_reset();
            use_stub = 1'b1;
            @(negedge clk);
            key   = tbl[v].key;
            start = 1'b1;
            @(posedge clk);
            cur = 0;
            for (int k = 0; k < 3; k++) begin
                tgt = INIT_CYC + 5 * k + 4;
                repeat (tgt - cur) @(posedge clk);
                cur = tgt;
                #1;
                check("stub_jTap", {24'd0, jTap}, {24'd0, tbl[v].exp_j[k]});
                check("stub_iTap", {24'd0, iTap}, 32'(k));
            end
            pulse_reset();
            use_stub = 1'b0;
        end

        full_run(24'h4A2F10, "key4A2F10");
        full_run(24'h000000, "key0");
        for (int r = 0; r < 2; r++) begin
            rk = 24'($urandom);
            full_run(rk, "rand");
        end

        // Reset pulse in the middle of a schedule.
        prep_ram();
        @(negedge clk);
        key   = 24'h4A2F10;
        start = 1'b1;
        @(posedge clk);
        repeat (699) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst700_sWren", {31'd0, sWren}, 32'd0);
        check("rst700_finished", {31'd0, finished}, 32'd0);
        check("rst700_iTap", {24'd0, iTap}, 32'd0);
        check("rst700_jTap", {24'd0, jTap}, 32'd0);
        w0 = wr_count;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst700_no_writes", 32'(wr_count - w0), 32'd0);
        full_run(24'h4A2F10, "post_rst");

        // Hold start past DONE, then drop it and rerun.
        full_run(24'h5C0FFE, "hold");
        w0  = wr_count;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (finished !== 1'b1) bad++;
        end
        check("hold_finished_drops", 32'(bad), 32'd0);
        check("hold_no_writes", 32'(wr_count - w0), 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("finished_fall", {31'd0, finished}, 32'd0);
        repeat (9) @(posedge clk);
        full_run(24'h5C0FFE, "rerun");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
